avalon_image_responder: RTL

- Avalon-MM slave that answers the cartoonifier's master read/write traffic.
- Holds the image frame in a word-addressed on-chip array.
- Returns read data with `slave_readdatavalid` after a fixed pipeline latency, and acknowledges each write with a `slave_writeresponsevalid` pulse.
- Sits between the cartoonifier top and the frame store; the same block serves as the memory model in system benches.

---
 rtl/avalon_pkg.sv | 23 ++
 rtl/read_pipe.sv | 78 +++++++
 rtl/avalon_image_responder.sv | 93 +++++++++
 3 files changed

// File: rtl/avalon_pkg.sv
// Shared types and constants for the Avalon-MM image responder and its read pipeline.
package avalon_pkg;

  localparam int AV_ADDR_W = 16;
  localparam int AV_DATA_W = 32;

  typedef logic [AV_DATA_W-1:0] word_t;
  typedef logic [AV_ADDR_W-1:0] addr_t;

  typedef struct packed {
    logic  valid;
    addr_t addr;
    logic  oob;
  } rd_stage_t;

  localparam word_t RD_OOB_DATA = '0;

  // An address is out of range when it lies at or beyond the implemented depth.
  function automatic logic addr_oob(input addr_t addr, input int unsigned depth);
    return 32'(addr) >= depth;
  endfunction

endpackage

// File: rtl/read_pipe.sv
// READ_LATENCY-deep read pipeline: carries accepted reads to the return port in order
// and tracks how many accepted reads have not yet returned.
module read_pipe
  import avalon_pkg::*;
#(
  parameter int READ_LATENCY = 2,
  parameter int MAX_PENDING  = 2
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 rd_accept,
  input  logic [AV_ADDR_W-1:0] rd_addr,
  input  logic                 rd_oob,
  output logic [AV_ADDR_W-1:0] s1_addr,
  output logic                 s1_oob,
  input  logic [AV_DATA_W-1:0] s1_data,
  output logic                 retire,
  output logic                 rd_full,
  output logic [AV_DATA_W-1:0] rd_data,
  output logic                 rd_data_valid
);

  localparam int PEND_W = $clog2(MAX_PENDING + 1);

  rd_stage_t         stage_q [READ_LATENCY];
  logic [PEND_W-1:0] pending;
  word_t             last_data;

  assign s1_addr = stage_q[0].addr;
  assign s1_oob  = stage_q[0].oob;
  assign retire  = stage_q[READ_LATENCY-1].valid;
  // A retiring read frees its slot in the same cycle, so a full pipe still accepts.
  assign rd_full = (pending == PEND_W'(MAX_PENDING)) && !retire;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int k = 0; k < READ_LATENCY; k++) stage_q[k] <= '0;
    end else begin
      stage_q[0] <= '{valid: rd_accept, addr: rd_addr, oob: rd_oob};
      for (int k = 1; k < READ_LATENCY; k++) stage_q[k] <= stage_q[k-1];
    end
  end

  // Data is captured when the read leaves stage 1 and then travels alongside it.
  if (READ_LATENCY > 1) begin : g_data
    word_t dat_q [READ_LATENCY-1];

    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        for (int k = 0; k < READ_LATENCY - 1; k++) dat_q[k] <= '0;
      end else begin
        dat_q[0] <= s1_data;
        for (int k = 1; k < READ_LATENCY - 1; k++) dat_q[k] <= dat_q[k-1];
      end
    end

    assign last_data = dat_q[READ_LATENCY-2];
  end else begin : g_no_data
    assign last_data = s1_data;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
      pending       <= '0;
    end else begin
      rd_data_valid <= retire;
      if (retire) rd_data <= last_data;
      if (rd_accept && !retire) begin
        pending <= pending + 1'b1;
      end else if (!rd_accept && retire) begin
        pending <= pending - 1'b1;
      end
    end
  end

endmodule

// File: rtl/avalon_image_responder.sv
// Avalon-MM slave holding the image frame in a word array; fixed-latency reads,
// single-cycle write responses, sticky out-of-range flag and traffic counters.
module avalon_image_responder
  import avalon_pkg::*;
#(
  parameter int ADDR_W       = AV_ADDR_W,
  parameter int DATA_W       = AV_DATA_W,
  parameter int DEPTH        = 4096,
  parameter int READ_LATENCY = 2,
  parameter int MAX_PENDING  = 2
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              slave_read,
  input  logic              slave_write,
  input  logic [ADDR_W-1:0] slave_address,
  input  logic [DATA_W-1:0] slave_writedata,
  input  logic              stall_inject,
  output logic              slave_waitrequest,
  output logic [DATA_W-1:0] slave_readdata,
  output logic              slave_readdatavalid,
  output logic              slave_writeresponsevalid,
  output logic              addr_error,
  output logic [31:0]       read_count,
  output logic [31:0]       write_count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  word_t mem [DEPTH];

  logic  req_oob;
  logic  wr_accept;
  logic  rd_accept;
  logic  rd_full;
  logic  retire;
  addr_t s1_addr;
  logic  s1_oob;
  word_t s1_data;
  logic  unused_s1_addr;

  // Handshake: a request is taken at a rising edge where it is asserted and
  // slave_waitrequest is low. A simultaneous read and write raises waitrequest,
  // yet the write is still taken; only the read must be held by the master.
  assign slave_waitrequest = stall_inject
                           || (slave_read && slave_write)
                           || (slave_read && rd_full);

  assign wr_accept = slave_write && !stall_inject;
  assign rd_accept = slave_read && !slave_waitrequest;
  assign req_oob   = addr_oob(slave_address, DEPTH);

  always_ff @(posedge clk) begin
    if (wr_accept && !req_oob) mem[slave_address[IDX_W-1:0]] <= slave_writedata;
  end

  // Registered-address read of the array: address held in stage 1, data captured on exit.
  assign s1_data        = s1_oob ? RD_OOB_DATA : mem[s1_addr[IDX_W-1:0]];
  assign unused_s1_addr = ^s1_addr;

  read_pipe #(
    .READ_LATENCY (READ_LATENCY),
    .MAX_PENDING  (MAX_PENDING)
  ) u_read_pipe (
    .clk           (clk),
    .n_rst         (n_rst),
    .rd_accept     (rd_accept),
    .rd_addr       (slave_address),
    .rd_oob        (req_oob),
    .s1_addr       (s1_addr),
    .s1_oob        (s1_oob),
    .s1_data       (s1_data),
    .retire        (retire),
    .rd_full       (rd_full),
    .rd_data       (slave_readdata),
    .rd_data_valid (slave_readdatavalid)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      slave_writeresponsevalid <= 1'b0;
      addr_error               <= 1'b0;
      read_count               <= '0;
      write_count              <= '0;
    end else begin
      slave_writeresponsevalid <= wr_accept;
      if ((wr_accept || rd_accept) && req_oob) addr_error <= 1'b1;
      if (slave_writeresponsevalid) write_count <= write_count + 32'd1;
      if (retire) read_count <= read_count + 32'd1;
    end
  end

endmodule
